dsp_frame_sequencer: RTL

DSP_FRAME_SEQUENCER -- requirements
Module: dsp_frame_sequencer

---
 rtl/dsp_frame_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/dsp_frame_sequencer.sv
// Frame sequencer for a DSP core: snapshots per-channel samples on each sample tick,
// waits out the core program, then streams the results channel by channel over valid/ready.
module dsp_frame_sequencer #(
    parameter int WIDTH       = 36,
    parameter int NUM_CH      = 8,
    parameter int PROG_CYCLES = 50
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             sample_tick,
    input  logic                             in_valid,
    input  logic [$clog2(NUM_CH)-1:0]        in_ch,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             core_start,
    output logic [NUM_CH-1:0][WIDTH-1:0]     core_inputs,
    input  logic [NUM_CH-1:0][WIDTH-1:0]     core_outputs,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(NUM_CH)-1:0]        out_ch,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             busy,
    output logic                             overrun,
    input  logic                             overrun_clr
);
    localparam int CW = $clog2(NUM_CH);
    localparam int NW = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [NW-1:0]                cnt_q, cnt_d;
    logic [CW-1:0]                och_q, och_d;
    logic [NUM_CH-1:0][WIDTH-1:0] shadow_q, cin_q, obuf_q;
    logic                         start_q, ovr_q;
    logic                         launch, capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        och_d   = och_q;
        launch  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (sample_tick) begin
                launch  = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            // The core_start cycle is the first RUN cycle, so CAPTURE lands PROG_CYCLES after it
            RUN: if (cnt_q == NW'(PROG_CYCLES - 1)) state_d = CAPTURE;
                 else cnt_d = cnt_q + NW'(1);
            CAPTURE: begin
                capture = 1'b1;
                och_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: if (out_ready) begin
                if (och_q == CW'(NUM_CH - 1)) begin
                    och_d   = '0;
                    state_d = IDLE;
                end else begin
                    och_d = och_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            och_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            och_q   <= och_d;
            start_q <= launch;
        end
    end

    // Shadow reads before this cycle's write, so a write coinciding with the tick waits a frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            cin_q    <= '0;
            obuf_q   <= '0;
        end else begin
            if (in_valid) shadow_q[in_ch] <= in_data;
            if (launch)   cin_q  <= shadow_q;
            if (capture)  obuf_q <= core_outputs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            ovr_q <= 1'b0;
        else if (sample_tick && state_q != IDLE) ovr_q <= 1'b1;
        else if (overrun_clr)                    ovr_q <= 1'b0;
    end

    assign core_start  = start_q;
    assign core_inputs = cin_q;
    assign out_valid   = (state_q == DRAIN);
    assign out_ch      = och_q;
    assign out_data    = out_valid ? obuf_q[och_q] : '0;
    assign busy        = (state_q != IDLE);
    assign overrun     = ovr_q;

endmodule
